// File: rtl/rsa_byte_frontend_if.sv
// Byte-stream bus between the host bridge and rsa_byte_frontend.
// master = host side, slave = frontend side.
interface rsa_byte_frontend_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/rsa_byte_frontend.sv
// Byte-stream front end for the modular exponentiator: load X/E/M, run, return Z.
// Optional watchdog on RUN enabled by defining RSA_TIMEOUT_EN.
module rsa_byte_frontend #(
  parameter int BITS           = 32,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                clk,
  input  logic                rst_n,
  rsa_byte_frontend_if.slave  bus,
  output logic [BITS-1:0]     exp_X,
  output logic [BITS-1:0]     exp_E,
  output logic [BITS-1:0]     exp_M,
  output logic                exp_go,
  input  logic                exp_done,
  input  logic [BITS-1:0]     exp_Z,
  output logic                busy,
  output logic                err
);

  localparam int NB  = BITS / 8;
  localparam int LCW = $clog2(3 * NB);
  localparam int OCW = (NB > 1) ? $clog2(NB) : 1;
`ifdef RSA_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  // Without the watchdog one bit is enough to mask stale done.
  localparam int RW = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    LOAD, RUN, SEND, REARM
  } state_t;

  state_t             state_q, state_d;
  logic [LCW-1:0]     lcnt_q, lcnt_d;
  logic [OCW-1:0]     ocnt_q, ocnt_d;
  logic [RW-1:0]      run_q, run_d;
  logic [BITS-1:0]    x_q, x_d;
  logic [BITS-1:0]    e_q, e_d;
  logic [BITS-1:0]    m_q, m_d;
  logic [BITS-1:0]    sh_q, sh_d;
  logic               go_q, go_d;
`ifdef RSA_TIMEOUT_EN
  logic               err_q, err_d;
`endif

  // Next-state: operand load, run supervision, result unload, rearm.
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    ocnt_d  = ocnt_q;
    run_d   = run_q;
    x_d     = x_q;
    e_d     = e_q;
    m_d     = m_q;
    sh_d    = sh_q;
    go_d    = go_q;
`ifdef RSA_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          if (lcnt_q < LCW'(NB))
            x_d = BITS'({x_q, bus.in_data});
          else if (lcnt_q < LCW'(2 * NB))
            e_d = BITS'({e_q, bus.in_data});
          else
            m_d = BITS'({m_q, bus.in_data});
          if (lcnt_q == LCW'(3 * NB - 1)) begin
            lcnt_d  = '0;
            run_d   = '0;
            go_d    = 1'b1;
            state_d = RUN;
          end else begin
            lcnt_d = lcnt_q + LCW'(1);
          end
        end
      end
      RUN: begin
        if (run_q != '1)
          run_d = run_q + RW'(1);
        if (run_q != '0 && exp_done) begin
          sh_d    = exp_Z;
          go_d    = 1'b0;
          ocnt_d  = '0;
          state_d = SEND;
        end
`ifdef RSA_TIMEOUT_EN
        else if (run_q == RW'(TIMEOUT_CYCLES)) begin
          sh_d    = '1;
          go_d    = 1'b0;
          err_d   = 1'b1;
          ocnt_d  = '0;
          state_d = SEND;
        end
`endif
      end
      SEND: begin
        if (bus.out_ready) begin
          sh_d = sh_q << 8;
          if (ocnt_q == OCW'(NB - 1))
            state_d = REARM;
          else
            ocnt_d = ocnt_q + OCW'(1);
        end
      end
      REARM: begin
        if (!exp_done) begin
          lcnt_d  = '0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State registers with synchronous reset taking priority everywhere.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      lcnt_q  <= '0;
      ocnt_q  <= '0;
      run_q   <= '0;
      x_q     <= '0;
      e_q     <= '0;
      m_q     <= '0;
      sh_q    <= '0;
      go_q    <= 1'b0;
`ifdef RSA_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      ocnt_q  <= ocnt_d;
      run_q   <= run_d;
      x_q     <= x_d;
      e_q     <= e_d;
      m_q     <= m_d;
      sh_q    <= sh_d;
      go_q    <= go_d;
`ifdef RSA_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.in_ready  = rst_n && (state_q == LOAD);
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_data  = sh_q[BITS-1 -: 8];
  assign exp_X         = x_q;
  assign exp_E         = e_q;
  assign exp_M         = m_q;
  assign exp_go        = go_q;
  assign busy          = (state_q != LOAD);
`ifdef RSA_TIMEOUT_EN
  assign err           = err_q;
`else
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_rsa_byte_frontend.sv
// Directed + randomized bench for rsa_byte_frontend (default build, BITS=32).
// Includes a behavioural exponentiator model with stale-done and slow-release knobs.
module tb_rsa_byte_frontend;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] exp_X, exp_E, exp_M;
  logic        exp_go;
  logic        exp_done = 1'b0;
  logic [31:0] exp_Z = '0;
  logic        busy, err;

  int checks = 0;
  int errors = 0;

  bit hang = 1'b0;
  bit stale_en = 1'b0;
  int go_cyc = 0;
  int lat = 2;
  int tail = 0;

  rsa_byte_frontend_if bus ();

  rsa_byte_frontend #(.BITS(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .exp_X    (exp_X),
    .exp_E    (exp_E),
    .exp_M    (exp_M),
    .exp_go   (exp_go),
    .exp_done (exp_done),
    .exp_Z    (exp_Z),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] modexp(input logic [31:0] x, e, m);
    longint unsigned r, b, mm;
    mm = {32'd0, m};
    if (mm == 0) return 32'd0;
    b = {32'd0, x} % mm;
    r = 1 % mm;
    for (int i = 31; i >= 0; i--) begin
      r = (r * r) % mm;
      if (e[i]) r = (r * b) % mm;
    end
    return r[31:0];
  endfunction

  // Exponentiator model: done after a random latency, held while go,
  // released a random number of cycles after go drops.
  always @(negedge clk) begin
    if (exp_go === 1'b1) begin
      go_cyc = go_cyc + 1;
      if (go_cyc == 1) lat = $urandom_range(2, 12);
      if (go_cyc == 1 && stale_en) begin
        exp_done = 1'b1;
        exp_Z    = 32'hDEAD_BEEF;
      end else if (!hang && go_cyc >= lat) begin
        exp_done = 1'b1;
        exp_Z    = modexp(exp_X, exp_E, exp_M);
        tail     = $urandom_range(0, 8);
      end else begin
        exp_done = 1'b0;
      end
    end else begin
      go_cyc = 0;
      if (tail > 0) tail = tail - 1;
      else exp_done = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send(input logic [31:0] x, e, m, input bit gaps);
    logic [95:0] s;
    int w;
    s = {x, e, m};
    for (int i = 0; i < 12; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = s[95 - 8 * i -: 8];
      w = 0;
      while (bus.in_ready !== 1'b1 && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (w >= 100) chk("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic recv(input int n, input bit stall, output logic [31:0] z);
    int w;
    logic [7:0] d0;
    z = '0;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (bus.out_valid !== 1'b1 && w < 200) begin
        @(negedge clk);
        w++;
      end
      chk("out_valid_wait", {63'd0, bus.out_valid}, 64'd1);
      if (i == 0) chk("go_low_at_send", {63'd0, exp_go}, 64'd0);
      if (stall) begin
        d0 = bus.out_data;
        repeat (5) begin
          bus.out_ready = 1'b0;
          @(negedge clk);
          chk("stall_hold", {55'd0, bus.out_valid, bus.out_data}, {55'd0, 1'b1, d0});
        end
      end
      bus.out_ready = 1'b1;
      z = {z[23:0], bus.out_data};
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy !== 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("busy_clear", {63'd0, busy}, 64'd0);
    chk("go_idle", {63'd0, exp_go}, 64'd0);
    chk("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
  endtask

  task automatic job(input logic [31:0] x, e, m, input logic [31:0] zexp,
                     input bit gaps, input bit stall, input string tag);
    logic [31:0] z;
    send(x, e, m, gaps);
    chk({tag, "_go"}, {63'd0, exp_go}, 64'd1);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    chk({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
    chk({tag, "_xem"}, {exp_X, exp_E ^ exp_M}, {x, e ^ m});
    recv(4, stall, z);
    chk({tag, "_z"}, {32'd0, z}, {32'd0, zexp});
    wait_idle();
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
  endtask

  initial begin
    logic [31:0] x, e, m, z;
    int seen;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_go", {63'd0, exp_go}, 64'd0);
    chk("rst_out", {55'd0, bus.out_valid, bus.out_data}, 64'd0);
    chk("rst_ops", {exp_X | exp_E | exp_M, 31'd0, err}, 64'd0);
    chk("rst_in_ready1", {63'd0, bus.in_ready}, 64'd1);

    // Basic and chained jobs; the chained run sees a stale done in RUN cycle 0
    job(32'd456, 32'd3, 32'd1189, 32'd822, 1'b0, 1'b0, "basic");
    stale_en = 1'b1;
    job(32'd822, 32'd187, 32'd1189, 32'd456, 1'b0, 1'b0, "chained");
    stale_en = 1'b0;

    // Random operands with input gaps and 5-cycle output stalls
    for (int k = 0; k < 4; k++) begin
      m = $urandom_range(2, 32'h7FFF_FFFF);
      x = $urandom % m;
      e = $urandom;
      stale_en = k[0];
      job(x, e, m, modexp(x, e, m), 1'b1, k < 2, "rand");
    end
    stale_en = 1'b0;

    // Reset mid-RUN
    hang = 1'b1;
    send(32'd5, 32'd7, 32'd11, 1'b0);
    repeat (5) @(negedge clk);
    chk("midrun_go", {63'd0, exp_go}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    hang = 1'b0;
    #1;
    chk("midrun_go_drop", {63'd0, exp_go}, 64'd0);
    chk("midrun_load", {62'd0, busy, bus.in_ready}, 64'd1);
    job(32'd5, 32'd7, 32'd11, modexp(32'd5, 32'd7, 32'd11), 1'b1, 1'b0, "after_run_rst");

    // Reset mid-SEND after two of four bytes
    send(32'd1234, 32'd65537, 32'd99991, 1'b0);
    recv(2, 1'b0, z);
    chk("midsend_hi", {48'd0, z[15:0]}, {48'd0, modexp(32'd1234, 32'd65537, 32'd99991) >> 16});
    rst_n = 1'b0;
    @(negedge clk);
    chk("midsend_valid", {63'd0, bus.out_valid}, 64'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    bus.out_ready = 1'b0;
    chk("midsend_no_more", seen, 64'd0);
    wait_idle();
    job(32'd3, 32'd4, 32'd7, 32'd4, 1'b0, 1'b0, "after_send_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog");
  end

endmodule
